// File: rtl/uart_rx_packet_parser.sv
// Frames SYNC/LEN/PAYLOAD/CHK packets from a UART byte stream, buffers good payloads
// and replays them over a valid/ready stream; malformed packets raise an error pulse.
module uart_rx_packet_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hAA,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 10850
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic [7:0] o_Data,
  output logic       o_Data_Valid,
  input  logic       i_Data_Ready,
  output logic       o_Data_Last,
  output logic       o_Pkt_Ok,
  output logic       o_Pkt_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Overrun
);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [TW-1:0] TMO_ONE   = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDX_ZERO  = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE   = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [1:0]    ERR_LEN   = 2'b01;
  localparam logic [1:0]    ERR_CHK   = 2'b10;
  localparam logic [1:0]    ERR_TMO   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t        r_State, w_State;
  logic [IW-1:0] r_Len, w_Len, r_Idx, w_Idx, r_Rd_Idx, w_Rd_Idx;
  logic [IW-1:0] w_Idx_Inc, w_Rd_Inc, w_Len_M1;
  logic [7:0]    r_Sum, w_Sum;
  logic [TW-1:0] r_Tmo_Cnt, w_Tmo_Cnt;
  logic          w_Tmo_Hit, w_Buf_We;
  logic [7:0]    r_Buf [MAX_LEN];
  logic [7:0]    r_Data, w_Data;
  logic          r_Data_Valid, w_Data_Valid, r_Data_Last, w_Data_Last;
  logic          r_Pkt_Ok, w_Pkt_Ok, r_Pkt_Err, w_Pkt_Err, r_Overrun, w_Overrun;
  logic [1:0]    r_Err_Code, w_Err_Code;

  assign w_Idx_Inc = r_Idx + IDX_ONE;
  assign w_Rd_Inc  = r_Rd_Idx + IDX_ONE;
  assign w_Len_M1  = r_Len - IDX_ONE;
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign w_Tmo_Hit = (!i_Rx_DV) && (r_Tmo_Cnt == TMO_LAST);

  // Next-state and next-output decode
  always_comb begin
    w_State      = r_State;
    w_Len        = r_Len;
    w_Idx        = r_Idx;
    w_Rd_Idx     = r_Rd_Idx;
    w_Sum        = r_Sum;
    w_Buf_We     = 1'b0;
    w_Data       = r_Data;
    w_Data_Valid = r_Data_Valid;
    w_Data_Last  = r_Data_Last;
    w_Pkt_Ok     = 1'b0;
    w_Pkt_Err    = 1'b0;
    w_Err_Code   = r_Err_Code;
    w_Overrun    = 1'b0;

    if ((r_State == S_LEN) || (r_State == S_PAYLOAD) || (r_State == S_CHK)) begin
      if (i_Rx_DV) begin
        w_Tmo_Cnt = {TW{1'b0}};
      end else if (r_Tmo_Cnt != TMO_LAST) begin
        w_Tmo_Cnt = r_Tmo_Cnt + TMO_ONE;
      end else begin
        w_Tmo_Cnt = r_Tmo_Cnt;
      end
    end else begin
      w_Tmo_Cnt = {TW{1'b0}};
    end

    case (r_State)
      S_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          w_State = S_LEN;
          w_Sum   = 8'h00;
        end else begin
          w_State = S_IDLE;
        end
      end
      S_LEN: begin
        if (i_Rx_DV) begin
          if ((i_Rx_Byte != 8'h00) && (i_Rx_Byte <= MAX_LEN_B)) begin
            w_State = S_PAYLOAD;
            w_Len   = i_Rx_Byte[IW-1:0];
            w_Sum   = i_Rx_Byte;
            w_Idx   = IDX_ZERO;
          end else begin
            w_State    = S_IDLE;
            w_Pkt_Err  = 1'b1;
            w_Err_Code = ERR_LEN;
          end
        end else if (w_Tmo_Hit) begin
          w_State    = S_IDLE;
          w_Pkt_Err  = 1'b1;
          w_Err_Code = ERR_TMO;
        end else begin
          w_State = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (i_Rx_DV) begin
          w_Buf_We = 1'b1;
          w_Sum    = r_Sum + i_Rx_Byte;
          w_Idx    = w_Idx_Inc;
          if (w_Idx_Inc == r_Len) begin
            w_State = S_CHK;
          end else begin
            w_State = S_PAYLOAD;
          end
        end else if (w_Tmo_Hit) begin
          w_State    = S_IDLE;
          w_Pkt_Err  = 1'b1;
          w_Err_Code = ERR_TMO;
        end else begin
          w_State = S_PAYLOAD;
        end
      end
      S_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == r_Sum) begin
            w_State      = S_DRAIN;
            w_Pkt_Ok     = 1'b1;
            w_Data_Valid = 1'b1;
            w_Data       = r_Buf[IDX_ZERO];
            w_Data_Last  = (r_Len == IDX_ONE);
            w_Rd_Idx     = IDX_ZERO;
          end else begin
            w_State    = S_IDLE;
            w_Pkt_Err  = 1'b1;
            w_Err_Code = ERR_CHK;
          end
        end else if (w_Tmo_Hit) begin
          w_State    = S_IDLE;
          w_Pkt_Err  = 1'b1;
          w_Err_Code = ERR_TMO;
        end else begin
          w_State = S_CHK;
        end
      end
      S_DRAIN: begin
        w_Overrun = i_Rx_DV;
        if (r_Data_Valid && i_Data_Ready) begin
          if (r_Data_Last) begin
            w_State      = S_IDLE;
            w_Data_Valid = 1'b0;
            w_Data_Last  = 1'b0;
          end else begin
            w_State     = S_DRAIN;
            w_Rd_Idx    = w_Rd_Inc;
            w_Data      = r_Buf[w_Rd_Inc];
            w_Data_Last = (w_Rd_Inc == w_Len_M1);
          end
        end else begin
          w_State = S_DRAIN;
        end
      end
      default: begin
        w_State      = S_IDLE;
        w_Data_Valid = 1'b0;
        w_Data_Last  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State      <= S_IDLE;
      r_Len        <= IDX_ZERO;
      r_Idx        <= IDX_ZERO;
      r_Rd_Idx     <= IDX_ZERO;
      r_Sum        <= 8'h00;
      r_Tmo_Cnt    <= {TW{1'b0}};
      r_Data       <= 8'h00;
      r_Data_Valid <= 1'b0;
      r_Data_Last  <= 1'b0;
      r_Pkt_Ok     <= 1'b0;
      r_Pkt_Err    <= 1'b0;
      r_Err_Code   <= 2'b00;
      r_Overrun    <= 1'b0;
    end else begin
      r_State      <= w_State;
      r_Len        <= w_Len;
      r_Idx        <= w_Idx;
      r_Rd_Idx     <= w_Rd_Idx;
      r_Sum        <= w_Sum;
      r_Tmo_Cnt    <= w_Tmo_Cnt;
      r_Data       <= w_Data;
      r_Data_Valid <= w_Data_Valid;
      r_Data_Last  <= w_Data_Last;
      r_Pkt_Ok     <= w_Pkt_Ok;
      r_Pkt_Err    <= w_Pkt_Err;
      r_Err_Code   <= w_Err_Code;
      r_Overrun    <= w_Overrun;
    end
  end

  // Payload buffer; contents are meaningless outside a packet so it has no reset
  always_ff @(posedge i_Clock) begin
    if (w_Buf_We) begin
      r_Buf[r_Idx] <= i_Rx_Byte;
    end
  end

  assign o_Data       = r_Data;
  assign o_Data_Valid = r_Data_Valid;
  assign o_Data_Last  = r_Data_Last;
  assign o_Pkt_Ok     = r_Pkt_Ok;
  assign o_Pkt_Err    = r_Pkt_Err;
  assign o_Err_Code   = r_Err_Code;
  assign o_Overrun    = r_Overrun;
endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Scoreboard bench for uart_rx_packet_parser: a byte-list packet model predicts events,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_uart_rx_packet_parser;
  localparam int MAXL = 16;
  localparam int TMO  = 64;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Rx_DV = 1'b0;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic       i_Data_Ready = 1'b1;
  logic [7:0] o_Data;
  logic       o_Data_Valid, o_Data_Last, o_Pkt_Ok, o_Pkt_Err, o_Overrun;
  logic [1:0] o_Err_Code;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pkt_q[$];
  logic [8:0] data_q[$];
  int         ovr_pend = 0;
  logic [7:0] pkt[$];
  int         rdy_mode = 0;
  logic       stall_prev = 1'b0;
  logic [8:0] stall_val = 9'd0;

  uart_rx_packet_parser #(.SYNC_BYTE(8'hAA), .MAX_LEN(MAXL), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Data(o_Data), .o_Data_Valid(o_Data_Valid), .i_Data_Ready(i_Data_Ready),
    .o_Data_Last(o_Data_Last), .o_Pkt_Ok(o_Pkt_Ok), .o_Pkt_Err(o_Pkt_Err),
    .o_Err_Code(o_Err_Code), .o_Overrun(o_Overrun));

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected output %0h (t=%0t)", nm, act, $time);
  endtask

  // Monitor: pop expected events whenever the DUT shows a pulse or a handshake
  always @(negedge i_Clock) begin
    if (i_Reset) begin
      stall_prev = 1'b0;
    end else begin
      if (o_Pkt_Ok || o_Pkt_Err) begin
        int a;
        a = (o_Pkt_Ok && o_Pkt_Err) ? 4 : (o_Pkt_Ok ? 0 : int'(o_Err_Code));
        if (pkt_q.size() == 0) flag("pkt_event_unexpected", 32'(a));
        else check("pkt_event", 32'(a), 32'(pkt_q.pop_front()));
      end
      if (o_Data_Valid) begin
        if (stall_prev) check("hold_during_stall", 32'({o_Data_Last, o_Data}), 32'(stall_val));
        if (i_Data_Ready) begin
          if (data_q.size() == 0) flag("data_unexpected", 32'({o_Data_Last, o_Data}));
          else check("data_byte", 32'({o_Data_Last, o_Data}), 32'(data_q.pop_front()));
        end
      end else if (stall_prev) begin
        flag("valid_dropped_in_stall", 32'(stall_val));
      end
      stall_prev = o_Data_Valid && !i_Data_Ready;
      stall_val  = {o_Data_Last, o_Data};
      if (o_Overrun) begin
        check("overrun_expected", 32'(ovr_pend > 0), 32'd1);
        if (ovr_pend > 0) ovr_pend--;
      end
    end
  end

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, 3 never
  initial begin
    forever begin
      @(posedge i_Clock);
      #1;
      case (rdy_mode)
        0: i_Data_Ready = 1'b1;
        1: i_Data_Ready = ~i_Data_Ready;
        2: i_Data_Ready = 1'($urandom_range(0, 1));
        default: i_Data_Ready = 1'b0;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(posedge i_Clock);
    #1;
    i_Rx_DV = 1'b0;
  endtask

  // Reference model: classify the byte list by the packet rules and queue expected events
  task automatic expect_pkt(output bit good, output bit complete);
    int L;
    logic [7:0] sum;
    good = 1'b0;
    complete = 1'b1;
    if (pkt.size() == 0 || pkt[0] != 8'hAA) return;
    if (pkt.size() < 2) begin pkt_q.push_back(3); complete = 1'b0; return; end
    L = int'(pkt[1]);
    if (L == 0 || L > MAXL) begin pkt_q.push_back(1); return; end
    if (pkt.size() < L + 3) begin pkt_q.push_back(3); complete = 1'b0; return; end
    sum = 8'(L);
    for (int i = 0; i < L; i++) sum = sum + pkt[2 + i];
    if (pkt[L + 2] != sum) begin pkt_q.push_back(2); return; end
    pkt_q.push_back(0);
    good = 1'b1;
    for (int i = 0; i < L; i++) data_q.push_back({(i == L - 1), pkt[2 + i]});
  endtask

  task automatic run_pkt(input bit inject, input bit long_gaps);
    bit good, complete;
    int n;
    expect_pkt(good, complete);
    foreach (pkt[i]) begin
      send_byte(pkt[i]);
      if (i != pkt.size() - 1) idle(long_gaps ? TMO - 2 : int'($urandom_range(0, 2)));
    end
    if (!complete) idle(TMO + 4);
    if (good && inject) begin
      idle(int'($urandom_range(0, int'(pkt[1]) - 1)));
      ovr_pend++;
      send_byte(($urandom_range(0, 1) == 0) ? 8'hAA : 8'($urandom_range(0, 255)));
    end
    n = 0;
    while (data_q.size() != 0 && n < 2000) begin
      idle(1);
      n++;
    end
    idle(2);
    check("pkt_events_pending", 32'(pkt_q.size()), 32'd0);
    check("data_pending", 32'(data_q.size()), 32'd0);
    check("overrun_pending", 32'(ovr_pend), 32'd0);
    check("valid_low_when_idle", 32'(o_Data_Valid), 32'd0);
    pkt_q.delete();
    data_q.delete();
    ovr_pend = 0;
  endtask

  task automatic gen_good(input int L, input bit bad_chk);
    logic [7:0] s;
    pkt = '{8'hAA, 8'(L)};
    s = 8'(L);
    for (int i = 0; i < L; i++) begin
      pkt.push_back(8'($urandom_range(0, 255)));
      s = s + pkt[pkt.size() - 1];
    end
    if (bad_chk) s = s + 8'($urandom_range(1, 255));
    pkt.push_back(s);
  endtask

  task automatic check_reset_outputs(input string nm);
    check(nm, 32'({o_Data, o_Data_Valid, o_Data_Last, o_Pkt_Ok, o_Pkt_Err, o_Err_Code, o_Overrun}), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int t;
    repeat (2) @(posedge i_Clock);
    #1;
    check_reset_outputs("reset_state");
    i_Reset = 1'b0;
    idle(2);

    pkt = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}; run_pkt(1'b0, 1'b0);
    pkt = '{8'h55, 8'h00};                             run_pkt(1'b0, 1'b0);
    pkt = '{8'hAA, 8'h02, 8'h01, 8'h02, 8'h00};        run_pkt(1'b0, 1'b0);
    pkt = '{8'hAA, 8'h01, 8'h05, 8'h06};               run_pkt(1'b0, 1'b0);
    pkt = '{8'hAA, 8'h00};                             run_pkt(1'b0, 1'b0);
    pkt = '{8'hAA, 8'h11};                             run_pkt(1'b0, 1'b0);
    pkt = '{8'hAA, 8'h02, 8'h7F};                      run_pkt(1'b0, 1'b0);
    pkt = '{8'h5A, 8'h00};                             run_pkt(1'b0, 1'b0);
    gen_good(3, 1'b0);                                 run_pkt(1'b0, 1'b1);
    rdy_mode = 1; gen_good(4, 1'b0);                   run_pkt(1'b0, 1'b0);
    rdy_mode = 0; gen_good(4, 1'b0);                   run_pkt(1'b1, 1'b0);
    gen_good(MAXL, 1'b0);                              run_pkt(1'b0, 1'b0);

    pkt = '{8'hAA, 8'h02, 8'h7F};                      run_pkt(1'b0, 1'b0);
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h01);
    #2; i_Reset = 1'b1; #1;
    check_reset_outputs("reset_mid_payload");
    @(posedge i_Clock); #3; i_Reset = 1'b0; idle(1);
    pkt = '{8'hAA, 8'h01, 8'h09, 8'h0A};               run_pkt(1'b0, 1'b0);

    rdy_mode = 3; gen_good(5, 1'b0);
    begin
      bit g, c;
      expect_pkt(g, c);
    end
    foreach (pkt[i]) send_byte(pkt[i]);
    idle(3);
    check("valid_held_no_ready", 32'(o_Data_Valid), 32'd1);
    check("ok_pulse_seen", 32'(pkt_q.size()), 32'd0);
    #2; i_Reset = 1'b1; #1;
    check_reset_outputs("reset_mid_drain");
    data_q.delete();
    @(posedge i_Clock); #3; i_Reset = 1'b0; rdy_mode = 0; idle(2);

    for (int k = 0; k < 80; k++) begin
      rdy_mode = int'($urandom_range(0, 2));
      t = int'($urandom_range(0, 9));
      case (t)
        0: begin
          pkt.delete();
          repeat ($urandom_range(1, 4)) begin
            b = 8'($urandom_range(0, 255));
            pkt.push_back((b == 8'hAA) ? 8'h55 : b);
          end
        end
        1: pkt = '{8'hAA, (($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)))};
        2: begin
          gen_good(int'($urandom_range(1, MAXL)), 1'b0);
          repeat ($urandom_range(2, pkt.size() - 1)) void'(pkt.pop_back());
        end
        3: gen_good(int'($urandom_range(1, MAXL)), 1'b1);
        default: gen_good(int'($urandom_range(1, MAXL)), 1'b0);
      endcase
      run_pkt($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
